sub64_seq: RTL

SUB64_SEQ -- requirements
Module: sub64_seq

---
 rtl/sub64_seq_pkg.sv | 14 +
 rtl/sub64_seq_if.sv | 28 ++
 rtl/sub64_seq_sub_slice.sv | 16 +
 rtl/sub64_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sub64_seq_pkg.sv
// Shared types and constants for the sequential 64-bit subtractor.
// Holds the FSM state type, the datapath width and the default slice width.
package sub64_seq_pkg;

    localparam int DATA_W      = 64;
    localparam int SLICE_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub64_seq_if.sv
// Operand/result handshake bundle for sub64_seq.
// master: producer/consumer side; slave: the subtractor.
interface sub64_seq_if;
    import sub64_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] diff;
    logic              bout;
    logic              zero;
    logic              ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );

endinterface

// File: rtl/sub64_seq_sub_slice.sv
// Combinational W-bit subtract slice: diff = a - b - bin.
// Ports: a, b, bin in; diff, bout (borrow-out) out.
module sub_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    // One extra bit: a negative result wraps and sets the top bit.
    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

endmodule

// File: rtl/sub64_seq.sv
// Sequential 64-bit subtractor, one SLICE_W slice per cycle, LSB first.
// Ports: clk, rst_n (sync, active-low), bus (sub64_seq_if.slave).
module sub64_seq
    import sub64_seq_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    sub64_seq_if.slave  bus
);

    localparam int NSL = DATA_W / SLICE_W;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int IW  = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    generate
        if ((DATA_W % SLICE_W) != 0) begin : g_bad_w
            $error("SLICE_W must divide DATA_W");
        end
    endgenerate

    state_t state, state_n;

    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  diff_q;
    logic [DATA_W-1:0]  diff_n;
    logic               bout_q;
    logic               zero_q;
    logic               ovf_q;
    logic               brw_q;
    logic [CW-1:0]      cnt_q;

    logic [IW-1:0]      base;
    logic [SLICE_W-1:0] sa;
    logic [SLICE_W-1:0] sb;
    logic [SLICE_W-1:0] sd;
    logic               sbo;

    logic accept;
    logic step;
    logic last;
    logic fin_zero;
    logic fin_ovf;

    assign accept = (state == IDLE) && bus.in_valid;
    assign step   = (state == CALC);
    assign last   = (cnt_q == LAST);

    // Bit offset of the current slice; always below DATA_W.
    assign base = IW'(int'(cnt_q) * SLICE_W);

    assign sa = SLICE_W'(a_q >> base);
    assign sb = SLICE_W'(b_q >> base);

    sub_slice #(
        .W (SLICE_W)
    ) u_slice (
        .a    (sa),
        .b    (sb),
        .bin  (brw_q),
        .diff (sd),
        .bout (sbo)
    );

    // Result with the current slice merged in; on the last
    // slice this is the final difference used for the flags.
    always_comb begin
        diff_n = diff_q;
        diff_n[base +: SLICE_W] = sd;
    end

    assign fin_zero = (diff_n == '0);
    assign fin_ovf  = (a_q[MSB] != b_q[MSB]) &&
                      (diff_n[MSB] != a_q[MSB]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            brw_q <= bus.bin;
            cnt_q <= '0;
        end else if (step) begin
            diff_q <= diff_n;
            brw_q  <= sbo;
            if (last) begin
                cnt_q  <= '0;
                bout_q <= sbo;
                zero_q <= fin_zero;
                ovf_q  <= fin_ovf;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

endmodule
